// File: rtl/i2c_slave_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_slave_pkg
// Description : Shared state encoding and bus-level constants for the I2C target
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_slave_pkg;

  // FSM state encoding (explicit 3-bit width)
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // Level of SDA in the 9th clock slot
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage : i2c_slave_pkg
`default_nettype wire

// File: rtl/i2c_slave_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_slave_line_filter
// Description : Metastability synchroniser followed by a glitch filter that
//               only accepts a new level after FILTER_LEN equal samples.
//               Output resets to 1 (idle bus level).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_line_filter #(
  parameter int SYNC_STAGES = 2,   // >= 2
  parameter int FILTER_LEN  = 3    // >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILTER_LEN-1:0]  hist_q;
  logic [FILTER_LEN-1:0]  hist_n;

  // Sample history including the sample being written this cycle, so the
  // decision is taken on the same edge the last required sample arrives.
  assign hist_n = {hist_q[FILTER_LEN-2:0], sync_q[SYNC_STAGES-1]};

  // Synchroniser chain, sample history and filtered level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
      dout   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= hist_n;
      if (&hist_n) begin
        dout <= 1'b1;
      end else if (~|hist_n) begin
        dout <= 1'b0;
      end
    end
  end

endmodule : i2c_slave_line_filter
`default_nettype wire

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target with 7-bit address match, byte-wide receive strobe
//               and transmit load handshake. Never stretches SCL; SDA is
//               open-drain (driven low or released).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h0F,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       rw
);

  logic       scl_f, sda_f;
  logic       scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [7:0] shreg_q, shreg_n;
  logic       sda_oe_q, sda_oe_n;
  logic       ack_seen_q, ack_seen_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_load_n, busy_n, rw_n;

  i2c_slave_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filt (
    .clk  (clk),
    .rst  (rst),
    .din  (SCL),
    .dout (scl_f)
  );

  i2c_slave_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filt (
    .clk  (clk),
    .rst  (rst),
    .din  (SDA),
    .dout (sda_f)
  );

  // Open-drain data line: only ever pull low
  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  assign scl_rise  =  scl_f & ~scl_d;
  assign scl_fall  = ~scl_f &  scl_d;
  assign start_det =  scl_f &  scl_d &  sda_d & ~sda_f;
  assign stop_det  =  scl_f &  scl_d & ~sda_d &  sda_f;
  assign byte_in   = {shreg_q[6:0], sda_f};

  // Previous filtered levels for edge and START/STOP detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      ack_seen_q <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
      rw         <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shreg_q    <= shreg_n;
      sda_oe_q   <= sda_oe_n;
      ack_seen_q <= ack_seen_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      tx_load    <= tx_load_n;
      busy       <= busy_n;
      rw         <= rw_n;
    end
  end

  // Next-state and datapath decode; STOP/START override every state.
  // In the two ACK-driving states the current SDA drive doubles as the
  // phase flag: released = waiting for the fall that opens the 9th clock,
  // driven = waiting for the fall that closes it.
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shreg_n    = shreg_q;
    sda_oe_n   = sda_oe_q;
    ack_seen_n = ack_seen_q;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_load_n  = 1'b0;
    busy_n     = busy;
    rw_n       = rw;

    if (stop_det) begin
      state_n    = ST_IDLE;
      bit_cnt_n  = 3'd0;
      sda_oe_n   = 1'b0;
      ack_seen_n = 1'b0;
      busy_n     = 1'b0;
    end else if (start_det) begin
      state_n    = ST_ADDR;
      bit_cnt_n  = 3'd0;
      sda_oe_n   = 1'b0;
      ack_seen_n = 1'b0;
      busy_n     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sda_oe_n = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_n = ST_ADDR_ACK;
                rw_n    = byte_in[0];
                busy_n  = 1'b1;
              end else begin
                state_n = ST_WAIT_STOP;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_n = 1'b1;
            end else if (!rw) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = ST_RX_BYTE;
            end else begin
              tx_load_n = 1'b1;
              shreg_n   = tx_data;
              sda_oe_n  = ~tx_data[7];
              bit_cnt_n = 3'd0;
              state_n   = ST_TX_BYTE;
            end
          end
        end

        ST_RX_BYTE: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_n  = byte_in;
              rx_valid_n = 1'b1;
              state_n    = ST_RX_ACK;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = ST_RX_BYTE;
            end
          end
        end

        ST_TX_BYTE: begin
          if (scl_fall) begin
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_n = 1'b0;
              state_n  = ST_TX_ACK;
            end else begin
              shreg_n  = {shreg_q[6:0], 1'b0};
              sda_oe_n = ~shreg_q[6];
            end
          end
        end

        ST_TX_ACK: begin
          sda_oe_n = 1'b0;
          if (scl_rise) begin
            if (sda_f == I2C_ACK) begin
              ack_seen_n = 1'b1;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else if (scl_fall && ack_seen_q) begin
            ack_seen_n = 1'b0;
            tx_load_n  = 1'b1;
            shreg_n    = tx_data;
            sda_oe_n   = ~tx_data[7];
            bit_cnt_n  = 3'd0;
            state_n    = ST_TX_BYTE;
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end

        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule : i2c_slave
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Self-checking bench for i2c_slave with a bit-level I2C master
//               and a transaction-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

  localparam logic [6:0] ADDR = 7'h0F;
  localparam int         Q    = 10;    // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, busy, rw;

  wire sda_bus;
  pullup (sda_bus);
  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

  i2c_slave #(
    .SLAVE_ADDR  (ADDR),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SCL      (scl),
    .SDA      (sda_bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .busy     (busy),
    .rw       (rw)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0, tx_cnt = 0, busy_cyc = 0, both_cnt = 0;

  // Event counters for the strobes and busy
  always @(posedge clk) begin
    if (rx_valid)            rx_cnt   <= rx_cnt + 1;
    if (tx_load)             tx_cnt   <= tx_cnt + 1;
    if (busy)                busy_cyc <= busy_cyc + 1;
    if (rx_valid && tx_load) both_cnt <= both_cnt + 1;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // One SCL clock; master puts b on SDA, returns the bus level mid-high.
  // glitch inserts a 2-clk low pulse on SCL during the high phase.
  task automatic i2c_bit(input logic b, input logic glitch, output logic s);
    m_sda_oe = ~b;
    wait_q();
    scl = 1'b1;
    if (glitch) begin
      repeat (3) @(negedge clk);
      scl = 1'b0;
      repeat (2) @(negedge clk);
      scl = 1'b1;
      repeat (Q - 5) @(negedge clk);
    end else begin
      wait_q();
    end
    s = sda_bus;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_sda_oe = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_sda_oe = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], glitch && (i == 4), s);
    i2c_bit(1'b1, 1'b0, ack);
  endtask

  // Write transfer; model: target acks only its own address, then every byte,
  // raising one rx strobe per byte with rx_data holding the last one.
  task automatic do_write(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input int n, input logic glitch, input string tag);
    logic [7:0] d [3];
    logic ack;
    bit   match;
    int   rx0, busy0;
    d = '{d0, d1, d2};
    match = (a == ADDR);
    rx0 = rx_cnt;
    busy0 = busy_cyc;
    i2c_start();
    write_byte({a, 1'b0}, 1'b0, ack);
    chk({tag, ":addr_ack"}, ack, match ? 1'b0 : 1'b1);
    if (match) begin
      chk({tag, ":busy"}, busy, 1'b1);
      chk({tag, ":rw"}, rw, 1'b0);
      for (int k = 0; k < n; k++) begin
        write_byte(d[k], glitch && (k == 0), ack);
        chk({tag, ":data_ack"}, ack, 1'b0);
      end
    end
    i2c_stop();
    chk({tag, ":rx_count"}, rx_cnt - rx0, match ? n : 0);
    if (match) chk({tag, ":rx_data"}, rx_data, d[n-1]);
    else       chk({tag, ":busy_never"}, busy_cyc - busy0, 0);
    chk({tag, ":busy_after_stop"}, busy, 1'b0);
  endtask

  // Read transfer; model: each byte returned equals the tx_data value
  // presented for it, one tx_load per byte, master NACKs the last.
  task automatic do_read(input logic [6:0] a, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [7:0] t2, input int n, input string tag);
    logic [7:0] t [3];
    logic [7:0] got;
    logic ack, s;
    bit   match;
    int   tx0;
    t = '{t0, t1, t2};
    match = (a == ADDR);
    tx0 = tx_cnt;
    tx_data = t[0];
    i2c_start();
    write_byte({a, 1'b1}, 1'b0, ack);
    chk({tag, ":addr_ack"}, ack, match ? 1'b0 : 1'b1);
    if (match) begin
      chk({tag, ":rw"}, rw, 1'b1);
      chk({tag, ":busy"}, busy, 1'b1);
      for (int k = 0; k < n; k++) begin
        for (int i = 7; i >= 0; i--) begin
          i2c_bit(1'b1, 1'b0, s);
          got[i] = s;
          if (i == 4 && k + 1 < n) tx_data = t[k+1];
        end
        i2c_bit((k == n - 1) ? 1'b1 : 1'b0, 1'b0, s);
        chk({tag, ":rd_data"}, got, t[k]);
      end
    end
    i2c_stop();
    chk({tag, ":tx_count"}, tx_cnt - tx0, match ? n : 0);
    chk({tag, ":busy_after_stop"}, busy, 1'b0);
  endtask

  initial begin
    logic       ack, s;
    logic [6:0] ra;
    logic [7:0] b0, b1, b2;
    int         n;

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset:sda", sda_bus, 1'b1);
    chk("reset:rx_data", rx_data, 8'h00);
    chk("reset:rx_valid", rx_valid, 1'b0);
    chk("reset:tx_load", tx_load, 1'b0);
    chk("reset:busy", busy, 1'b0);
    chk("reset:rw", rw, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Basic write, basic read, wrong address
    do_write(ADDR, 8'hAB, 8'h00, 8'h00, 1, 1'b0, "wr_basic");
    do_read(ADDR, 8'h5C, 8'h00, 8'h00, 1, "rd_basic");
    do_write(7'h10, 8'h33, 8'h00, 8'h00, 1, 1'b0, "wr_wrong_addr");

    // Repeated START: write 8'h12 then read back without STOP
    i2c_start();
    write_byte({ADDR, 1'b0}, 1'b0, ack);
    chk("rs:wr_addr_ack", ack, 1'b0);
    write_byte(8'h12, 1'b0, ack);
    chk("rs:data_ack", ack, 1'b0);
    tx_data = 8'h96;
    i2c_start();
    write_byte({ADDR, 1'b1}, 1'b0, ack);
    chk("rs:rd_addr_ack", ack, 1'b0);
    chk("rs:rx_data", rx_data, 8'h12);
    chk("rs:rw", rw, 1'b1);
    chk("rs:busy", busy, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 1'b0, s);
      b0[i] = s;
    end
    i2c_bit(1'b1, 1'b0, s);
    chk("rs:rd_data", b0, 8'h96);
    i2c_stop();

    // SCL glitch mid-byte must not count as a clock
    do_write(ADDR, 8'hA5, 8'h3C, 8'h00, 2, 1'b1, "glitch");

    // Reset while the target holds SDA low for the data ACK
    i2c_start();
    write_byte({ADDR, 1'b0}, 1'b0, ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b0[i] ^ 1'b1, 1'b0, s);
    m_sda_oe = 1'b0;
    wait_q();
    chk("rst_mid:sda_driven", sda_bus, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid:sda_released", sda_bus, 1'b1);
    chk("rst_mid:rx_data", rx_data, 8'h00);
    chk("rst_mid:busy", busy, 1'b0);
    chk("rst_mid:rw", rw, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_q();
    i2c_stop();
    do_write(ADDR, 8'hC3, 8'h00, 8'h00, 1, 1'b0, "after_rst");

    // Randomised transfers
    for (int it = 0; it < 8; it++) begin
      ra = ($urandom_range(0, 1) == 0) ? ADDR : 7'($urandom);
      n  = int'($urandom_range(1, 3));
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(ra, b0, b1, b2, n, 1'b0, $sformatf("rand_wr%0d", it));
      else                           do_read(ra, b0, b1, b2, n, $sformatf("rand_rd%0d", it));
    end

    chk("strobe_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_i2c_slave
`default_nettype wire
